// File: rtl/trace_memory_ctrl.sv
// Trace/stream memory controller: one synchronous RAM used either as a trigger-frozen
// ring buffer (trace mode) or as a FIFO (stream mode).
module trace_memory_ctrl #(
  parameter int unsigned TRB_WIDTH      = 32,
  parameter int unsigned TRB_DEPTH      = 64,
  parameter int unsigned TRB_DELAY_BITS = 16
) (
  input  logic                         FPGA_CLK_I,
  input  logic                         RST_NI,
  input  logic                         MODE_I,
  input  logic                         TRG_EVENT_I,
  input  logic [TRB_DELAY_BITS-1:0]    TRG_DELAY_I,
  output logic                         TRG_DELAYED_O,
  output logic [$clog2(TRB_DEPTH)-1:0] EVENT_ADDR_O,
  input  logic                         STORE_I,
  input  logic [TRB_WIDTH-1:0]         DATA_I,
  output logic                         STORE_PERM_O,
  output logic                         OVERFLOW_O,
  input  logic                         LOAD_REQUEST_I,
  output logic                         LOAD_GRANT_O,
  output logic [TRB_WIDTH-1:0]         DATA_O
);

  localparam int unsigned AW = $clog2(TRB_DEPTH);
  localparam logic [AW:0] Full = (AW+1)'(TRB_DEPTH);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StArmed  = 2'd1;
  localparam logic [1:0] StFrozen = 2'd2;

  logic [TRB_WIDTH-1:0] mem [TRB_DEPTH];

  logic                      mode_q;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [AW:0]               count_q, count_d;
  logic [AW:0]               rd_left_q, rd_left_d;
  logic                      pending_q, pending_d;
  logic [1:0]                state_q, state_d;
  logic [TRB_DELAY_BITS:0]   dly_cnt_q, dly_cnt_d;
  logic [AW-1:0]             event_addr_q, event_addr_d;
  logic                      overflow_q, overflow_d;
  logic                      grant_q;
  logic [TRB_WIDTH-1:0]      data_q;

  logic mode_chg, grantable, store_acc, read_fire;

  always_comb begin
    mode_chg     = MODE_I != mode_q;
    STORE_PERM_O = mode_q ? (count_q < Full) : (state_q != StFrozen);
    grantable    = mode_q ? (count_q != '0) : ((state_q == StFrozen) && (rd_left_q != '0));
    store_acc    = STORE_I && STORE_PERM_O && !mode_chg;
    read_fire    = pending_q && grantable && !mode_chg;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    rd_left_d    = rd_left_q;
    pending_d    = pending_q;
    state_d      = state_q;
    dly_cnt_d    = dly_cnt_q;
    event_addr_d = event_addr_q;
    overflow_d   = overflow_q;

    if (mode_chg) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      rd_left_d    = '0;
      pending_d    = 1'b0;
      state_d      = StIdle;
      dly_cnt_d    = '0;
      event_addr_d = '0;
      overflow_d   = 1'b0;
    end else begin
      if (store_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (STORE_I && !STORE_PERM_O) overflow_d = 1'b1;

      // A request landing on the issuing edge merges into the one being served.
      if (read_fire) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        pending_d = 1'b0;
      end else if (LOAD_REQUEST_I) begin
        pending_d = 1'b1;
      end

      if (mode_q) begin
        case ({store_acc, read_fire})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end else begin
        if (store_acc && (count_q != Full)) count_d = count_q + 1'b1;
        if (read_fire) rd_left_d = rd_left_q - 1'b1;

        case (state_q)
          StIdle: begin
            if (TRG_EVENT_I) begin
              state_d      = StArmed;
              event_addr_d = wr_ptr_d;
              dly_cnt_d    = {1'b0, TRG_DELAY_I} + 1'b1;
            end
          end
          StArmed: begin
            if (store_acc) begin
              dly_cnt_d = dly_cnt_q - 1'b1;
              if (dly_cnt_q == (TRB_DELAY_BITS+1)'(1)) begin
                state_d   = StFrozen;
                // Oldest word: wr_ptr once the ring has wrapped, else address 0.
                rd_ptr_d  = (count_d == Full) ? wr_ptr_d : '0;
                rd_left_d = count_d;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge FPGA_CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      mode_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_left_q    <= '0;
      pending_q    <= 1'b0;
      state_q      <= StIdle;
      dly_cnt_q    <= '0;
      event_addr_q <= '0;
      overflow_q   <= 1'b0;
      grant_q      <= 1'b0;
      data_q       <= '0;
    end else begin
      mode_q       <= MODE_I;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_left_q    <= rd_left_d;
      pending_q    <= pending_d;
      state_q      <= state_d;
      dly_cnt_q    <= dly_cnt_d;
      event_addr_q <= event_addr_d;
      overflow_q   <= overflow_d;
      grant_q      <= read_fire;
      if (read_fire) data_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge FPGA_CLK_I) begin
    if (store_acc) mem[wr_ptr_q] <= DATA_I;
  end

  assign TRG_DELAYED_O = (state_q == StFrozen);
  assign EVENT_ADDR_O  = event_addr_q;
  assign OVERFLOW_O    = overflow_q;
  assign LOAD_GRANT_O  = grant_q;
  assign DATA_O        = data_q;

endmodule
